// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the register file and its read ports.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_GP   = 5'd28;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational register file read port with $0 forcing
// and an optional write-through compare.
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              byp_vld,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data
);

  logic nz;
  logic hit;

  always_comb begin
    nz      = (rd_addr != ADDR_W'(REG_ZERO));
    hit     = byp_vld & nz & (byp_addr == rd_addr);
    rd_data = '0;
    if (hit) begin
      rd_data = byp_data;
    end else if (nz) begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 MIPS register file fed by the WB stage.
// Define REG_FILE_BYPASS_EN for same-cycle WB->ID write-through.
module reg_file_wb
  import mips_pkg::*;
#(
  parameter int              DATA_W  = DATA_W_DEF,
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_07FC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_RegWrite,
  input  logic [ADDR_W-1:0] e_WBAddr,
  input  logic [DATA_W-1:0] e_WBData,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int NREG = 2**ADDR_W;

`ifdef REG_FILE_BYPASS_EN
  localparam logic BYP_EN = 1'b1;
`else
  localparam logic BYP_EN = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              we;
  logic              byp_vld;

  // Address/data are only looked at once the enable is known good.
  always_comb begin
    we         = e_RegWrite && (e_WBAddr != ADDR_W'(REG_ZERO));
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (we) begin
      regs_d[e_WBAddr] = e_WBData;
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_GP] <= GP_INIT;
      regs_q[REG_SP] <= SP_INIT;
      wr_count_q     <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign byp_vld  = BYP_EN & e_RegWrite & ~reset;
  assign wr_count = wr_count_q;

  reg_file_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rs (
    .rd_addr (rs_addr),
    .regs    (regs_q),
    .byp_vld (byp_vld),
    .byp_addr(e_WBAddr),
    .byp_data(e_WBData),
    .rd_data (rs_data)
  );

  reg_file_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rt (
    .rd_addr (rt_addr),
    .regs    (regs_q),
    .byp_vld (byp_vld),
    .byp_addr(e_WBAddr),
    .byp_data(e_WBData),
    .rd_data (rt_data)
  );

  reg_file_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dbg (
    .rd_addr (dbg_addr),
    .regs    (regs_q),
    .byp_vld (1'b0),
    .byp_addr(e_WBAddr),
    .byp_data(e_WBData),
    .rd_data (dbg_data)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized scoreboard bench for reg_file_wb.
// Honors REG_FILE_BYPASS_EN when computing expectations.
module tb_reg_file_wb;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] SP0 = 32'h0000_07FC;
  localparam logic [31:0] GP0 = 32'h0000_1800;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_RegWrite;
  logic [4:0]  e_WBAddr;
  logic [31:0] e_WBData;
  logic [4:0]  rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data;
  logic [15:0] wr_count;

  reg_file_wb dut (
    .clk       (clk),
    .reset     (reset),
    .e_RegWrite(e_RegWrite),
    .e_WBAddr  (e_WBAddr),
    .e_WBData  (e_WBData),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] dbg;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain array plus an integer write counter.
  logic [31:0] mdl [32];
  int          mdl_cnt;
  bit          mdl_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rd(input logic [4:0] a, input bit port);
    if (a == 0) return 32'd0;
    if (port && BYP && !reset && e_RegWrite && e_WBAddr == a)
      return e_WBData;
    return mdl[a];
  endfunction

  task automatic cyc(input bit rst, input bit w,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input logic [4:0] da, input string tag);
    exp_t e;
    reset = rst;
    e_RegWrite = w;
    e_WBAddr = w ? wa : 5'bx;
    e_WBData = w ? wd : 32'bx;
    rs_addr = ra;
    rt_addr = rb;
    dbg_addr = da;
    if (mdl_ok) begin
      e.rs  = rd(ra, 1'b1);
      e.rt  = rd(rb, 1'b1);
      e.dbg = rd(da, 1'b0);
      e.cnt = 16'(mdl_cnt);
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 32'd0;
      mdl[28] = GP0;
      mdl[29] = SP0;
      mdl_cnt = 0;
      mdl_ok = 1'b1;
    end else if (w && wa != 0) begin
      mdl[wa] = wd;
      if (mdl_cnt < 65535) mdl_cnt++;
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so one sample per cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 4;
      if (rs_data !== e.rs) begin
        errors++;
        $display("FAIL %s rs_data got %h want %h", e.tag, rs_data, e.rs);
      end
      if (rt_data !== e.rt) begin
        errors++;
        $display("FAIL %s rt_data got %h want %h", e.tag, rt_data, e.rt);
      end
      if (dbg_data !== e.dbg) begin
        errors++;
        $display("FAIL %s dbg_data got %h want %h", e.tag, dbg_data, e.dbg);
      end
      if (wr_count !== e.cnt) begin
        errors++;
        $display("FAIL %s wr_count got %h want %h", e.tag, wr_count, e.cnt);
      end
    end
  end

  initial begin
    logic [4:0] a;
    reset = 1'b1;
    e_RegWrite = 1'b0;
    e_WBAddr = '0;
    e_WBData = '0;
    rs_addr = '0;
    rt_addr = '0;
    dbg_addr = '0;
    #1;

    cyc(1, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i), "rst_scan");

    cyc(0, 1, 8, 32'hDEADBEEF, 0, 0, 8, "wr8");
    cyc(0, 0, 0, 0, 8, 8, 8, "rd8");

    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, "wr0");
    cyc(0, 0, 0, 0, 0, 0, 0, "rd0");

    cyc(0, 1, 5, 32'h12345678, 5, 5, 5, "haz5");
    cyc(0, 0, 0, 0, 5, 5, 5, "haz5_after");

    cyc(0, 1, 29, 32'h0BAD_0BAD, 29, 3, 29, "wr29");
    cyc(1, 1, 29, 32'hAAAA5555, 29, 29, 29, "rst_wr");
    cyc(0, 0, 0, 0, 29, 28, 29, "rst_wr_after");

    for (int i = 0; i < 3000; i++) begin
      a = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
          $urandom,
          a, ($urandom_range(0, 1) != 0) ? a : 5'($urandom),
          5'($urandom), "rand");
    end

    for (int i = 0; i < 65540; i++) begin
      a = 5'($urandom_range(1, 31));
      cyc(0, 1, a, $urandom, a, 5'($urandom),
          5'($urandom), "sat");
    end
    cyc(0, 1, 0, 32'h1, 0, 1, 2, "sat_hold");
    cyc(0, 0, 0, 0, 28, 29, 30, "sat_end");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file; the consumer end of the writeback interface (e_RegWrite / e_WBAddr / e_WBData) driven by the WB stage.
- Provides two combinational read ports (rs, rt) to the ID stage and one combinational debug read port.
- Register $0 is hardwired to zero. $sp and $gp take programmable reset values.
- Optional write-through bypass lets ID see a same-cycle WB write.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width (2**ADDR_W registers)
- SP_INIT, 32'h0000_07FC, reset value of register 29 ($sp)
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- e_RegWrite  in  1  writeback enable from WB stage
- e_WBAddr  in  ADDR_W  writeback destination index
- e_WBData  in  DATA_W  writeback data
- rs_addr  in  ADDR_W  read port A index (instruction rs field)
- rt_addr  in  ADDR_W  read port B index (instruction rt field)
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- dbg_addr  in  ADDR_W  debug/testbench read index
- dbg_data  out  DATA_W  debug read data, combinational, never bypassed
- wr_count  out  16  count of committed writes since reset

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on posedge clk.
- Reset values: on a posedge with reset=1, every register becomes 0, except reg28=GP_INIT and reg29=SP_INIT; wr_count becomes 0.
  - reset takes priority over a simultaneous write; that write is dropped.
  - Read outputs reflect the reset values from the cycle after the reset edge.
- Write:
  - On a posedge with reset=0, e_RegWrite=1 and e_WBAddr!=0: reg[e_WBAddr] <= e_WBData.
  - wr_count increments by 1 on each such write and saturates at 16'hFFFF (no wrap).
  - A write to index 0 is ignored and does not increment wr_count.
- Read:
  - rs_data = (rs_addr==0) ? 0 : reg[rs_addr]; rt_data likewise.
  - Reads are purely combinational with zero latency; no read enable.
- Same-cycle write/read to the same index: governed by the optional feature below.
- Both read ports may address the same register, or the register being written, simultaneously; each port resolves independently.
- X-safety: with e_RegWrite=0, e_WBAddr and e_WBData may be X without corrupting any state.
- Write latency: data written at edge N is visible on the non-bypassed ports from edge N onward.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined:
  - If e_RegWrite=1, e_WBAddr!=0 and e_WBAddr==rs_addr, then rs_data = e_WBData in the same cycle. The rt port behaves the same way.
  - This closes the WB->ID hazard without a stall; reset=1 suppresses the bypass.
  - dbg_data is never bypassed.
- Undefined:
  - The read ports return stored contents only.
  - The hazard detection unit must stall ID one cycle on a WB/ID index match.

Decomposition:
- Shared package mips_pkg:
  - REG_ZERO=5'd0, REG_GP=5'd28, REG_SP=5'd29, REG_RA=5'd31
  - DATA_W and ADDR_W defaults
  - typedefs reg_idx_t and word_t
- One natural sub-module, reg_file_rd_port: a combinational read mux with zero-index forcing and the optional bypass compare, instantiated three times (bypass tied off on the debug instance).
- The storage array and wr_count stay in the top module.

Test Plan:
- Reset: drive reset=1 for one edge, then read all 32 indices via dbg_addr -> 0, except idx28=32'h0000_1800 and idx29=32'h0000_07FC; wr_count=0.
- Basic write/read: write 32'hDEADBEEF to idx 8, then on the next cycle set rs_addr=8 and rt_addr=8 -> both ports read DEADBEEF; wr_count=1.
- $0 protection: write 32'hFFFFFFFF to idx 0, then read rs_addr=0 -> 0; wr_count unchanged.
- Same-cycle hazard: write 32'h12345678 to idx 5 while rs_addr=5 (stored value 0).
  - With REG_FILE_BYPASS_EN: rs_data=12345678 in that cycle.
  - Without it: rs_data=0 in that cycle and 12345678 after the edge.
- Reset vs. write collision: reset=1 and a write of 32'hAAAA5555 to idx 29 on the same edge -> idx29=SP_INIT and wr_count=0.
- Saturation: force 65540 valid writes -> wr_count holds at 16'hFFFF.
